// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: reads the 64-bit word at pc and returns one
// 32-bit instruction per request, with misalign, timeout and stale-drop handling.
//
// Ports:
//   clk, rstn           clock, async active-low reset
//   fetch_en, pc        one-cycle fetch request and its address
//   instr, instr_en     returned instruction and its one-cycle strobe
//   fetch_err           with instr_en: misaligned pc or memory timeout
//   busy                high whenever a fetch is in progress
//   mem_req, mem_addr   memory read request (held until mem_gnt), aligned address
//   mem_gnt             memory accepted the request
//   mem_rvalid, mem_rdata  memory read response
module ifetch_resp #(
  parameter int AW  = 64,
  parameter int IW  = 32,
  parameter int DW  = 64,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          fetch_en,
  input  logic [AW-1:0] pc,
  output logic [IW-1:0] instr,
  output logic          instr_en,
  output logic          fetch_err,
  output logic          busy,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t        state;
  logic [AW-1:2] pc_q;
  logic [IW-1:0] instr_q;
  logic          err_q;
  logic          drop_q;
  logic [7:0]    tmo_cnt;

  assign instr     = instr_q;
  assign fetch_err = instr_en & err_q;
  assign mem_addr  = {pc_q[AW-1:3], 3'b000};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      tmo_cnt  <= '0;
      instr_en <= 1'b0;
      busy     <= 1'b0;
      mem_req  <= 1'b0;
    end else begin
      instr_en <= 1'b0;
      // A late response outside WAIT only retires the pending discard.
      if (mem_rvalid && state != WAIT)
        drop_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fetch_en) begin
            pc_q <= pc[AW-1:2];
            busy <= 1'b1;
            if (pc[1:0] != 2'b00) begin
              err_q    <= 1'b1;
              instr_q  <= '0;
              instr_en <= 1'b1;
              state    <= RESP;
            end else begin
              mem_req <= 1'b1;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            tmo_cnt <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (drop_q) begin
              drop_q <= 1'b0;
            end else begin
              instr_q  <= pc_q[2] ? mem_rdata[DW-1:IW]
                                  : mem_rdata[IW-1:0];
              err_q    <= 1'b0;
              instr_en <= 1'b1;
              state    <= RESP;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            // The abandoned read may still answer later: discard it.
            instr_q  <= '0;
            err_q    <= 1'b1;
            drop_q   <= 1'b1;
            instr_en <= 1'b1;
            state    <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
